// File: rtl/stopwatch_time_counter.sv
// MM:SS BCD stopwatch counter driven by a synchronized 1 Hz tick, with a
// start/stop/clear FSM and a lap hold on the displayed digits.
module stopwatch_time_counter #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       lap_active,
    output logic       wrap
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    localparam logic [3:0] PRESCALE_LAST = 4'(PRESCALE - 1);

    // bit 0 tick, bit 1 start_stop, bit 2 clear, bit 3 lap
    logic [3:0] raw_level;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] prev;
    logic [3:0] event_pulse;
    logic [1:0] arm_count;
    logic       armed;

    logic tick_event;
    logic start_stop_event;
    logic clear_event;
    logic lap_event;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [3:0] prescale_count;
    logic [3:0] prescale_next;

    logic [3:0] cnt_sec_ones, cnt_sec_tens, cnt_min_ones, cnt_min_tens;
    logic [3:0] nxt_sec_ones, nxt_sec_tens, nxt_min_ones, nxt_min_tens;
    logic       lap_next;
    logic       wrap_next;
    logic       count_enable;
    logic       second_step;

    assign raw_level = {lap, clear, start_stop, tick_in};

    // Two-flop synchronizer plus previous-value flop for each input
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= raw_level;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Arm counter saturates at 3 so levels held through reset release never fire
    always_ff @(posedge clock_in) begin
        if (reset) begin
            arm_count <= '0;
        end else if (arm_count != 2'd3) begin
            arm_count <= arm_count + 2'd1;
        end
    end

    assign armed            = (arm_count == 2'd3);
    assign event_pulse      = armed ? (sync2 & ~prev) : '0;
    assign tick_event       = event_pulse[0];
    assign start_stop_event = event_pulse[1];
    assign clear_event      = event_pulse[2];
    assign lap_event        = event_pulse[3];

    // Increment decision uses the current state, so it is independent of any transition this cycle
    assign count_enable = tick_event && (state == RUN);
    assign second_step  = count_enable && (prescale_count == PRESCALE_LAST);

    // Next-state, prescale, BCD cascade and lap control
    always_comb begin
        state_next    = state;
        prescale_next = prescale_count;
        nxt_sec_ones  = cnt_sec_ones;
        nxt_sec_tens  = cnt_sec_tens;
        nxt_min_ones  = cnt_min_ones;
        nxt_min_tens  = cnt_min_tens;
        lap_next      = lap_active;
        wrap_next     = 1'b0;

        if (count_enable) begin
            if (prescale_count == PRESCALE_LAST) begin
                prescale_next = '0;
            end else begin
                prescale_next = prescale_count + 4'd1;
            end
        end

        if (second_step) begin
            if (cnt_sec_ones != 4'd9) begin
                nxt_sec_ones = cnt_sec_ones + 4'd1;
            end else begin
                nxt_sec_ones = '0;
                if (cnt_sec_tens != 4'd5) begin
                    nxt_sec_tens = cnt_sec_tens + 4'd1;
                end else begin
                    nxt_sec_tens = '0;
                    if (cnt_min_ones != 4'd9) begin
                        nxt_min_ones = cnt_min_ones + 4'd1;
                    end else begin
                        nxt_min_ones = '0;
                        if (cnt_min_tens != 4'd5) begin
                            nxt_min_tens = cnt_min_tens + 4'd1;
                        end else begin
                            nxt_min_tens = '0;
                            wrap_next    = 1'b1;
                        end
                    end
                end
            end
        end

        case (state)
            IDLE: begin
                if (start_stop_event) begin
                    state_next    = RUN;
                    prescale_next = '0;
                end
            end
            RUN: begin
                if (start_stop_event) begin
                    state_next = PAUSE;
                end
                if (lap_event) begin
                    lap_next = ~lap_active;
                end
            end
            PAUSE: begin
                if (lap_event) begin
                    lap_next = 1'b0;
                end
                if (start_stop_event) begin
                    state_next = RUN;
                end else if (clear_event) begin
                    state_next    = IDLE;
                    prescale_next = '0;
                    nxt_sec_ones  = '0;
                    nxt_sec_tens  = '0;
                    nxt_min_ones  = '0;
                    nxt_min_tens  = '0;
                    lap_next      = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, internal count and registered outputs; display tracks the live count unless lap hold is set
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state          <= IDLE;
            prescale_count <= '0;
            cnt_sec_ones   <= '0;
            cnt_sec_tens   <= '0;
            cnt_min_ones   <= '0;
            cnt_min_tens   <= '0;
            sec_ones       <= '0;
            sec_tens       <= '0;
            min_ones       <= '0;
            min_tens       <= '0;
            running        <= 1'b0;
            lap_active     <= 1'b0;
            wrap           <= 1'b0;
        end else begin
            state          <= state_next;
            prescale_count <= prescale_next;
            cnt_sec_ones   <= nxt_sec_ones;
            cnt_sec_tens   <= nxt_sec_tens;
            cnt_min_ones   <= nxt_min_ones;
            cnt_min_tens   <= nxt_min_tens;
            running        <= (state_next == RUN);
            lap_active     <= lap_next;
            wrap           <= wrap_next;
            if (!lap_next) begin
                sec_ones <= nxt_sec_ones;
                sec_tens <= nxt_sec_tens;
                min_ones <= nxt_min_ones;
                min_tens <= nxt_min_tens;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: two instances (PRESCALE 1 and 4) share
// stimulus and are compared against a seconds-based reference model.
module tb_stopwatch_time_counter;

    logic clock_in = 1'b0;
    logic reset;
    logic tick_in;
    logic start_stop;
    logic clear;
    logic lap;

    logic [1:0][3:0] d_so;
    logic [1:0][3:0] d_st;
    logic [1:0][3:0] d_mo;
    logic [1:0][3:0] d_mt;
    logic [1:0]      d_run;
    logic [1:0]      d_lap;
    logic [1:0]      d_wrap;

    int total = 0;
    int bad   = 0;

    // reference model: state 0 idle, 1 run, 2 pause
    int m_sec[2];
    int m_pre[2];
    int m_state[2];
    int m_lap[2];
    int m_snap[2];
    int m_wraps[2];
    int pre_of[2] = '{1, 4};

    int wrap_cnt[2]  = '{0, 0};
    int wrap_len[2]  = '{0, 0};
    int wrap_max[2]  = '{0, 0};

    always #5 clock_in = ~clock_in;

    stopwatch_time_counter #(.PRESCALE(1)) dut1 (
        .clock_in(clock_in), .reset(reset), .tick_in(tick_in),
        .start_stop(start_stop), .clear(clear), .lap(lap),
        .sec_ones(d_so[0]), .sec_tens(d_st[0]), .min_ones(d_mo[0]), .min_tens(d_mt[0]),
        .running(d_run[0]), .lap_active(d_lap[0]), .wrap(d_wrap[0])
    );

    stopwatch_time_counter #(.PRESCALE(4)) dut4 (
        .clock_in(clock_in), .reset(reset), .tick_in(tick_in),
        .start_stop(start_stop), .clear(clear), .lap(lap),
        .sec_ones(d_so[1]), .sec_tens(d_st[1]), .min_ones(d_mo[1]), .min_tens(d_mt[1]),
        .running(d_run[1]), .lap_active(d_lap[1]), .wrap(d_wrap[1])
    );

    // wrap pulse monitor: number of pulses and longest high run
    always @(negedge clock_in) begin
        for (int i = 0; i < 2; i++) begin
            if (d_wrap[i] === 1'b1) begin
                if (wrap_len[i] == 0) wrap_cnt[i]++;
                wrap_len[i]++;
                if (wrap_len[i] > wrap_max[i]) wrap_max[i] = wrap_len[i];
            end else begin
                wrap_len[i] = 0;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sec[i] = 0; m_pre[i] = 0; m_state[i] = 0; m_lap[i] = 0; m_snap[i] = 0;
        end
    endtask

    task automatic ev_tick(input int i);
        if (m_state[i] == 1) begin
            m_pre[i]++;
            if (m_pre[i] == pre_of[i]) begin
                m_pre[i] = 0;
                m_sec[i] = (m_sec[i] + 1) % 3600;
                if (m_sec[i] == 0) m_wraps[i]++;
            end
        end
    endtask

    task automatic ev_ss(input int i);
        if (m_state[i] == 0) begin
            m_state[i] = 1;
            m_pre[i] = 0;
        end else if (m_state[i] == 1) begin
            m_state[i] = 2;
        end else begin
            m_state[i] = 1;
        end
    endtask

    task automatic ev_clear(input int i);
        if (m_state[i] == 2) begin
            m_state[i] = 0; m_sec[i] = 0; m_pre[i] = 0; m_lap[i] = 0;
        end
    endtask

    task automatic ev_lap(input int i);
        if (m_state[i] == 1) begin
            if (m_lap[i] == 0) begin
                m_lap[i] = 1;
                m_snap[i] = m_sec[i];
            end else begin
                m_lap[i] = 0;
            end
        end else if (m_state[i] == 2) begin
            m_lap[i] = 0;
        end
    endtask

    function automatic int shown(input int i);
        return (m_lap[i] != 0) ? m_snap[i] : m_sec[i];
    endfunction

    task automatic check_all(input string tag);
        int s;
        for (int i = 0; i < 2; i++) begin
            s = shown(i);
            chk($sformatf("%s.d%0d.sec_ones", tag, i), 32'(d_so[i]), 32'(s % 10));
            chk($sformatf("%s.d%0d.sec_tens", tag, i), 32'(d_st[i]), 32'((s % 60) / 10));
            chk($sformatf("%s.d%0d.min_ones", tag, i), 32'(d_mo[i]), 32'((s / 60) % 10));
            chk($sformatf("%s.d%0d.min_tens", tag, i), 32'(d_mt[i]), 32'(s / 600));
            chk($sformatf("%s.d%0d.running", tag, i), 32'(d_run[i]), 32'(m_state[i] == 1));
            chk($sformatf("%s.d%0d.lap_active", tag, i), 32'(d_lap[i]), 32'(m_lap[i]));
            chk($sformatf("%s.d%0d.wrap", tag, i), 32'(d_wrap[i]), 32'd0);
        end
    endtask

    // raise the selected inputs together for hi cycles, then hold low long enough to settle
    task automatic act(input bit t, input bit s, input bit c, input bit l, input int hi);
        @(negedge clock_in);
        tick_in = t; start_stop = s; clear = c; lap = l;
        repeat (hi) @(negedge clock_in);
        tick_in = 0; start_stop = 0; clear = 0; lap = 0;
        repeat (3) @(negedge clock_in);
        for (int i = 0; i < 2; i++) begin
            if (l) ev_lap(i);
            if (t) ev_tick(i);
            if (c) ev_clear(i);
            if (s) ev_ss(i);
        end
    endtask

    task automatic tick_rand();
        act(1'b1, 1'b0, 1'b0, 1'b0, int'($urandom_range(1, 4)));
    endtask

    initial begin
        int old_so;
        int r;
        m_wraps = '{0, 0};
        model_reset();

        // reset with start_stop held high across release
        reset = 1; tick_in = 0; start_stop = 1; clear = 0; lap = 0;
        repeat (3) @(negedge clock_in);
        check_all("reset");
        reset = 0;
        repeat (10) @(negedge clock_in);
        check_all("held_release");

        // release, then a clean press; running rises at the third edge after first sampling
        start_stop = 0;
        repeat (4) @(negedge clock_in);
        start_stop = 1;
        @(posedge clock_in); #1;
        chk("press_edge_k", 32'(d_run[0]), 32'd0);
        @(posedge clock_in); #1;
        chk("press_edge_k1", 32'(d_run[0]), 32'd0);
        @(posedge clock_in); #1;
        chk("press_edge_k2.d0", 32'(d_run[0]), 32'd1);
        chk("press_edge_k2.d1", 32'(d_run[1]), 32'd1);
        @(negedge clock_in);
        start_stop = 0;
        repeat (3) @(negedge clock_in);
        for (int i = 0; i < 2; i++) ev_ss(i);
        check_all("started");

        // tick latency: digit changes two edges after first sampling
        old_so = m_sec[0] % 10;
        tick_in = 1;
        @(posedge clock_in); #1;
        chk("tick_edge_k", 32'(d_so[0]), 32'(old_so));
        @(posedge clock_in); #1;
        chk("tick_edge_k1", 32'(d_so[0]), 32'(old_so));
        @(posedge clock_in); #1;
        for (int i = 0; i < 2; i++) ev_tick(i);
        chk("tick_edge_k2", 32'(d_so[0]), 32'(m_sec[0] % 10));
        repeat ($urandom_range(0, 5)) @(negedge clock_in);
        @(negedge clock_in);
        tick_in = 0;
        repeat (3) @(negedge clock_in);
        for (int n = 0; n < 74; n++) tick_rand();
        check_all("t75");
        chk("t75.d0.total", 32'(m_sec[0]), 32'd75);

        // run up to 59:58, then across the wrap
        while (m_sec[0] != 3598) tick_rand();
        check_all("t5958");
        tick_rand();
        check_all("t5959");
        tick_rand();
        check_all("t0000");
        chk("wrap_count.d0", 32'(wrap_cnt[0]), 32'(m_wraps[0]));
        chk("wrap_count.d1", 32'(wrap_cnt[1]), 32'(m_wraps[1]));
        chk("wrap_width.d0", 32'(wrap_max[0]), 32'd1);

        // lap hold
        for (int n = 0; n < 10; n++) tick_rand();
        check_all("lap_pre");
        act(1'b0, 1'b0, 1'b0, 1'b1, 2);
        check_all("lap_on");
        for (int n = 0; n < 5; n++) tick_rand();
        check_all("lap_hold");
        act(1'b0, 1'b0, 1'b0, 1'b1, 1);
        check_all("lap_off");

        // clear ignored in RUN, stop, ticks ignored in PAUSE, clear to IDLE
        act(1'b0, 1'b0, 1'b1, 1'b0, 2);
        check_all("clear_run");
        act(1'b0, 1'b1, 1'b0, 1'b0, 2);
        for (int n = 0; n < 3; n++) tick_rand();
        check_all("pause_ticks");
        act(1'b0, 1'b0, 1'b1, 1'b0, 3);
        check_all("clear_pause");

        // tick with start from IDLE is not counted; tick with stop from RUN is counted
        act(1'b1, 1'b1, 1'b0, 1'b0, 2);
        check_all("tick_start");
        for (int n = 0; n < 9; n++) tick_rand();
        check_all("pre9");
        tick_rand();
        tick_rand();
        act(1'b1, 1'b1, 1'b0, 1'b0, 2);
        check_all("tick_stop");
        chk("tick_stop.d1.total", 32'(m_sec[1]), 32'd3);
        act(1'b0, 1'b1, 1'b0, 1'b0, 1);
        check_all("resume");

        // random event mix
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5)      tick_rand();
            else if (r == 6) act(1'b0, 1'b1, 1'b0, 1'b0, int'($urandom_range(1, 3)));
            else if (r == 7) act(1'b0, 1'b0, 1'b0, 1'b1, int'($urandom_range(1, 3)));
            else if (r == 8) act(1'b0, 1'b0, 1'b1, 1'b0, int'($urandom_range(1, 3)));
            else             act(1'b1, 1'b1, 1'b0, 1'b0, int'($urandom_range(1, 3)));
            check_all($sformatf("rand%0d", n));
        end

        // reset mid-count overrides a pending tick event
        if (m_state[0] != 1) act(1'b0, 1'b1, 1'b0, 1'b0, 1);
        if (m_state[0] != 1) act(1'b0, 1'b1, 1'b0, 1'b0, 1);
        for (int n = 0; n < 7; n++) tick_rand();
        check_all("pre_reset");
        tick_in = 1;
        @(negedge clock_in);
        @(negedge clock_in);
        reset = 1;
        @(posedge clock_in); #1;
        model_reset();
        check_all("mid_reset");
        @(negedge clock_in);
        reset = 0;
        tick_in = 0;
        repeat (6) @(negedge clock_in);
        check_all("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
- Downstream consumer of the 1 Hz square wave produced by the stopwatch clock divider.
- Synchronizes that wave into the 50 MHz system clock domain and edge-detects it to produce a one-cycle count enable.
- Maintains an MM:SS BCD time count (00:00–59:59) under a start/stop/clear/lap control FSM.
- Drives the seven-segment decode stage.

Parameters:
- PRESCALE, default 1: number of tick_in rising edges per one-second increment, legal range 1–15.

Ports:
- clock_in input 1: 50 MHz system clock; all logic on its rising edge.
- reset input 1: synchronous, active-high reset.
- tick_in input 1: 1 Hz square wave from the clock divider, asynchronous level.
- start_stop input 1: debounced push-button level, asynchronous.
- clear input 1: debounced push-button level, asynchronous.
- lap input 1: debounced push-button level, asynchronous.
- sec_ones output 4: BCD 0–9.
- sec_tens output 4: BCD 0–5.
- min_ones output 4: BCD 0–9.
- min_tens output 4: BCD 0–5.
- running output 1: high while the FSM is in RUN.
- lap_active output 1: high while the displayed value is frozen.
- wrap output 1: one-cycle pulse on 59:59 -> 00:00.

Behaviour:
- Reset (synchronous, active-high):
  - All digits 0; state IDLE; running=0, lap_active=0, wrap=0.
  - All sync and edge flops cleared; prescale counter cleared; arm counter cleared.
- Input conditioning:
  - Each of tick_in, start_stop, clear and lap goes through a 2-flop synchronizer plus a previous-value flop.
  - Event pulse = sync2 & ~prev.
  - An input first sampled high at edge k produces its pulse in the cycle after edge k+1; its effect is registered at edge k+2.
- Arming: a 2-bit arm counter counts up after reset deassertion. All four event pulses are suppressed until it saturates at 3, so levels already high at reset release never produce events.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start_stop event -> RUN; prescale counter cleared.
  - RUN + start_stop event -> PAUSE.
  - PAUSE + start_stop event -> RUN; prescale counter retained.
  - PAUSE + clear event -> IDLE; digits zeroed, prescale cleared, lap hold released.
  - Clear event in IDLE: no effect. Clear event in RUN: ignored.
- Counting:
  - Only on a tick event while the registered state is RUN.
  - The prescale counter increments per tick event. At PRESCALE-1 it returns to 0 and the time advances by one second.
  - BCD cascade: sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones; min_ones 9->0 carries into min_tens; min_tens 5->0 completes the wrap.
  - On the wrap, all digits become 0, wrap=1 for exactly one cycle, and counting continues.
- Simultaneous events: in the same cycle as a state transition, the increment is decided from the current (pre-transition) state.
  - A tick event coinciding with a RUN->PAUSE start_stop event is counted.
  - A tick event coinciding with an IDLE->RUN start_stop event is not counted.
- Lap:
  - A lap event in RUN toggles lap_active.
  - While lap_active=1, the output digits hold the snapshot captured at assertion. The internal count keeps advancing.
  - Deassertion restores the live count to the outputs at the next edge.
  - A lap event in PAUSE clears lap_active. A lap event in IDLE is ignored.
  - wrap is driven from the internal count regardless of lap_active.
- Output timing: all outputs are registered; no combinational path from input to output.
- Reset mid-operation: a synchronous reset overrides all events in the same cycle.

Test Plan:
- Reset released with start_stop held high -> state stays IDLE, running=0, digits 00:00. Release the button, press again -> running=1 exactly at the 3rd clock_in edge after the press is sampled.
- IDLE, start, then 75 tick_in rising edges -> digits 01:15. Each digit change occurs 2 edges after tick_in is first sampled high; exactly one increment per tick_in period regardless of high-phase length.
- Preload by running to 59:58, then 2 ticks -> 59:59 then 00:00. wrap high exactly 1 cycle; running stays 1.
- RUN at 00:10: lap, then 5 ticks -> outputs stay 00:10 with lap_active=1. Lap again -> outputs show 00:15 next edge.
- RUN: clear -> ignored. Stop -> PAUSE, 3 ticks -> digits unchanged. Clear -> 00:00, IDLE, lap_active=0.
- PRESCALE=4: start, 9 ticks -> 00:02. Tick event and stop event in the same cycle -> that tick is counted. Assert reset mid-count -> 00:00 and IDLE at the next edge.
